// File: rtl/lfu_pkg.sv
// Shared types and sizing for the LFU button front-end.
package lfu_pkg;

  localparam int unsigned N_BTN = 5;

  typedef enum logic [1:0] {
    IDLE,
    CHK_PRESS,
    HELD,
    CHK_REL
  } btn_state_t;

  typedef logic [N_BTN-1:0] btn_vec_t;

endpackage

// File: rtl/lfu_button_conditioner_if.sv
// Button-side bundle: raw levels in, press pulses / debounced levels / pending presses out.
interface lfu_button_conditioner_if import lfu_pkg::*; ();

  btn_vec_t btn_raw;
  logic     b1;
  logic     b2;
  logic     b3;
  logic     b4;
  logic     b5;
  btn_vec_t pressed;
  btn_vec_t pend;

  // Driver of the raw buttons, consumer of the pulses (board / bench side).
  modport master (
    output btn_raw,
    input  b1, b2, b3, b4, b5, pressed, pend
  );

  // The conditioner itself.
  modport slave (
    input  btn_raw,
    output b1, b2, b3, b4, b5, pressed, pend
  );

endinterface

// File: rtl/lfu_debounce_ch.sv
// One button channel: 2-flop synchroniser, stable-level counter and press/release FSM.
// o_accept is a single-cycle strobe on the clock where a press is accepted.
module lfu_debounce_ch import lfu_pkg::*; #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn_raw,
  output logic o_pressed,
  output logic o_accept
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             r_sync1;
  logic             r_sync2;
  btn_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pressed;
  logic             w_cnt_done;

  // Bring the asynchronous button level into the clk domain.
  // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_cnt_done = (r_cnt == CNT_LAST);

  // Press/release debounce FSM; the counter only advances while the new level holds, so it never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_pressed <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_sync2) begin
            r_state <= CHK_PRESS;
            r_cnt   <= '0;
          end
        end
        CHK_PRESS: begin
          if (!r_sync2) begin
            r_state <= IDLE;
          end else if (w_cnt_done) begin
            r_state   <= HELD;
            r_pressed <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        HELD: begin
          if (!r_sync2) begin
            r_state <= CHK_REL;
            r_cnt   <= '0;
          end
        end
        CHK_REL: begin
          if (r_sync2) begin
            r_state <= HELD;
          end else if (w_cnt_done) begin
            r_state   <= IDLE;
            r_pressed <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_pressed = r_pressed;
  assign o_accept  = (r_state == CHK_PRESS) && r_sync2 && w_cnt_done;

endmodule

// File: rtl/lfu_button_conditioner.sv
// Debounces N_BTN raw buttons and serialises accepted presses into one-hot single-cycle
// pulses b1..b5 for the LFU tracker. Lowest index issues first; nothing is dropped.
module lfu_button_conditioner import lfu_pkg::*; #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  lfu_button_conditioner_if.slave  bus
);

  btn_vec_t w_accept;
  btn_vec_t w_pressed;
  btn_vec_t w_grant;
  btn_vec_t r_pend;
  btn_vec_t r_b;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    lfu_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_btn_raw (bus.btn_raw[g]),
      .o_pressed (w_pressed[g]),
      .o_accept  (w_accept[g])
    );
  end

  // Pick the lowest pending button (isolate lowest set bit).
  // NOTE: combinational blocks assign every output on every path so no latch is inferred.
  always_comb begin
    w_grant = '0;
    w_grant = r_pend & (~r_pend + btn_vec_t'(1));
  end

  // Pending set/clear and registered issue; a new accept overrides the clear of its own bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend <= '0;
      r_b    <= '0;
    end else begin
      r_pend <= (r_pend & ~w_grant) | w_accept;
      r_b    <= w_grant;
    end
  end

  assign bus.b1      = r_b[0];
  assign bus.b2      = r_b[1];
  assign bus.b3      = r_b[2];
  assign bus.b4      = r_b[3];
  assign bus.b5      = r_b[4];
  assign bus.pressed = w_pressed;
  assign bus.pend    = r_pend;

endmodule

// File: tb/tb_lfu_button_conditioner.sv
// Bench for lfu_button_conditioner with DEBOUNCE_CYCLES=4. The reference model treats each
// button as a debounced level that flips once the synchronised input has disagreed with it
// for DEBOUNCE_CYCLES+1 consecutive clocks; each flip to 1 queues a press, and one queued
// press (lowest index) is issued per clock. Tick counts below are rising edges after the
// stimulus change, so an isolated press shows its pulse after edge 2+4+1+1 = 8.
module tb_lfu_button_conditioner;
  import lfu_pkg::*;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  lfu_button_conditioner_if bus_if ();

  lfu_button_conditioner #(
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  bit m_h1   [N_BTN];
  bit m_h2   [N_BTN];
  bit m_deb  [N_BTN];
  int m_run  [N_BTN];
  bit m_pend [N_BTN];
  int m_issue;

  // Observation bookkeeping for directed steps
  int tnow;
  int pulse_cnt  [N_BTN];
  int last_pulse [N_BTN];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N_BTN; i++) begin
      m_h1[i]   = 1'b0;
      m_h2[i]   = 1'b0;
      m_deb[i]  = 1'b0;
      m_run[i]  = 0;
      m_pend[i] = 1'b0;
    end
    m_issue = -1;
  endfunction

  function automatic void model_step(input btn_vec_t raw);
    int lowest;
    bit s;
    lowest = -1;
    for (int i = 0; i < N_BTN; i++)
      if (m_pend[i] && lowest < 0) lowest = i;
    if (lowest >= 0) m_pend[lowest] = 1'b0;
    m_issue = lowest;
    for (int i = 0; i < N_BTN; i++) begin
      s       = m_h2[i];
      m_h2[i] = m_h1[i];
      m_h1[i] = raw[i];
      if (s != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] == D + 1) begin
          m_deb[i] = s;
          m_run[i] = 0;
          if (s) m_pend[i] = 1'b1;
        end
      end else begin
        m_run[i] = 0;
      end
    end
  endfunction

  task automatic compare_all();
    btn_vec_t obs_b, exp_b, exp_pressed, exp_pend;
    obs_b = {bus_if.b5, bus_if.b4, bus_if.b3, bus_if.b2, bus_if.b1};
    exp_b = '0;
    if (m_issue >= 0) exp_b[m_issue] = 1'b1;
    for (int i = 0; i < N_BTN; i++) begin
      exp_pressed[i] = m_deb[i];
      exp_pend[i]    = m_pend[i];
    end
    check($sformatf("b@%0d", tnow), obs_b, exp_b);
    check($sformatf("pressed@%0d", tnow), bus_if.pressed, exp_pressed);
    check($sformatf("pend@%0d", tnow), bus_if.pend, exp_pend);
    check($sformatf("onehot@%0d", tnow), ($countones(obs_b) <= 1), 1);
    for (int i = 0; i < N_BTN; i++)
      if (obs_b[i]) begin
        pulse_cnt[i]++;
        last_pulse[i] = tnow;
      end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_step(bus_if.btn_raw);
    else     model_reset();
    @(negedge clk);
    tnow++;
    compare_all();
  endtask

  task automatic clear_counts();
    tnow = 0;
    for (int i = 0; i < N_BTN; i++) begin
      pulse_cnt[i]  = 0;
      last_pulse[i] = -1;
    end
  endtask

  initial begin
    model_reset();
    clear_counts();
    bus_if.btn_raw = '0;
    #2 rst = 1'b0;

    // 1. Reset held with every button down: outputs stay 0, then b1..b5 in order.
    bus_if.btn_raw = 5'h1F;
    repeat (4) tick();
    rst = 1'b1;
    clear_counts();
    repeat (14) tick();
    for (int i = 0; i < N_BTN; i++) begin
      check($sformatf("t1_cnt_b%0d", i + 1), pulse_cnt[i], 1);
      check($sformatf("t1_at_b%0d", i + 1), last_pulse[i], 8 + i);
    end
    bus_if.btn_raw = '0;
    repeat (10) tick();

    // 2. Bounce on button 0 is rejected.
    clear_counts();
    bus_if.btn_raw = 5'b00001; tick();
    bus_if.btn_raw = 5'b00000; tick();
    bus_if.btn_raw = 5'b00001; tick();
    bus_if.btn_raw = 5'b00000; tick();
    repeat (10) tick();
    check("t2_no_b1", pulse_cnt[0], 0);
    check("t2_pressed0", bus_if.pressed[0], 1'b0);

    // 3. Clean press of button 2.
    clear_counts();
    bus_if.btn_raw = 5'b00100;
    repeat (20) tick();
    check("t3_cnt_b3", pulse_cnt[2], 1);
    check("t3_at_b3", last_pulse[2], 8);
    check("t3_pressed_held", bus_if.pressed[2], 1'b1);
    bus_if.btn_raw = '0;
    repeat (10) tick();
    check("t3_pressed_rel", bus_if.pressed[2], 1'b0);

    // 4. Simultaneous presses of buttons 1 and 3 are serialised.
    clear_counts();
    bus_if.btn_raw = 5'b01010;
    repeat (15) tick();
    check("t4_at_b2", last_pulse[1], 8);
    check("t4_at_b4", last_pulse[3], 9);
    check("t4_cnt_b2", pulse_cnt[1], 1);
    check("t4_cnt_b4", pulse_cnt[3], 1);
    bus_if.btn_raw = '0;
    repeat (10) tick();

    // 5. Three separate presses of button 0 give three pulses.
    clear_counts();
    repeat (3) begin
      bus_if.btn_raw = 5'b00001;
      repeat (10) tick();
      bus_if.btn_raw = 5'b00000;
      repeat (10) tick();
    end
    check("t5_cnt_b1", pulse_cnt[0], 3);

    // 6. Reset while buttons 1 and 2 are pending discards them.
    clear_counts();
    bus_if.btn_raw = 5'b00110;
    repeat (7) tick();
    check("t6_pend_before", bus_if.pend, 5'b00110);
    #1 rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("t6_pend_async", bus_if.pend, 5'b00000);
    bus_if.btn_raw = '0;
    repeat (3) tick();
    rst = 1'b1;
    clear_counts();
    repeat (15) tick();
    check("t6_no_b2", pulse_cnt[1], 0);
    check("t6_no_b3", pulse_cnt[2], 0);

    // 7. Randomised bursts against the reference model.
    repeat (60) begin
      bus_if.btn_raw = btn_vec_t'($urandom);
      repeat ($urandom_range(1, 9)) tick();
    end
    bus_if.btn_raw = '0;
    repeat (15) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
